// File: rtl/pwm_reg_bank.sv
// Multi-channel PWM generator with a byte-wide register bank for an SPI slave.
// Define PWM_SHADOW_EN to double-buffer PERIOD/DUTY so updates land on a period boundary.
module pwm_reg_bank #(
  parameter int NUM_CH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        addr,
  input  logic [7:0]        data_wr,
  input  logic              wr_en,
  output logic [7:0]        data_rd,
  output logic [NUM_CH-1:0] pwm_out
);

  localparam logic [7:0] ADDR_CTRL = 8'h00;
  localparam logic [7:0] ADDR_PSC  = 8'h01;
  localparam logic [7:0] ADDR_PER  = 8'h10;
  localparam logic [7:0] ADDR_DUTY = 8'h20;
  localparam logic [7:0] ADDR_ID   = 8'h3F;
  localparam logic [7:0] ID_VALUE  = 8'hA5;

  logic              wr_en_q;
  logic              armed;
  logic              strobe;
  logic [NUM_CH-1:0] ctrl;
  logic [7:0]        prescale;
  logic [7:0]        psc_cnt;
  logic              tick;
  logic [7:0]        period_w [NUM_CH];
  logic [7:0]        duty_w   [NUM_CH];
  logic [7:0]        period_a [NUM_CH];
  logic [7:0]        duty_a   [NUM_CH];
  logic [7:0]        cnt      [NUM_CH];
  logic [NUM_CH-1:0] sel_per;
  logic [NUM_CH-1:0] sel_duty;
  logic [NUM_CH-1:0] wrap;

  // armed blocks a write from a wr_en level that was already high across reset release
  assign strobe = wr_en & ~wr_en_q & armed;
  assign tick   = (psc_cnt == prescale);

  always_comb begin
    sel_per  = '0;
    sel_duty = '0;
    wrap     = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      sel_per[i]  = (addr == ADDR_PER + 8'(i));
      sel_duty[i] = (addr == ADDR_DUTY + 8'(i));
      wrap[i]     = ctrl[i] & tick & (cnt[i] == period_a[i]);
    end
  end

  always_comb begin
    data_rd = 8'h00;
    if (addr == ADDR_CTRL)
      data_rd = 8'(ctrl);
    else if (addr == ADDR_PSC)
      data_rd = prescale;
    else if (addr == ADDR_ID)
      data_rd = ID_VALUE;
    for (int i = 0; i < NUM_CH; i++) begin
      if (sel_per[i])
        data_rd = period_w[i];
      if (sel_duty[i])
        data_rd = duty_w[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_en_q  <= 1'b0;
      armed    <= 1'b0;
      ctrl     <= '0;
      prescale <= 8'h00;
      psc_cnt  <= 8'h00;
      for (int i = 0; i < NUM_CH; i++) begin
        period_w[i] <= 8'hFF;
        duty_w[i]   <= 8'h00;
      end
    end else begin
      wr_en_q <= wr_en;
      if (!wr_en)
        armed <= 1'b1;
      if ((strobe && addr == ADDR_PSC) || tick)
        psc_cnt <= 8'h00;
      else
        psc_cnt <= psc_cnt + 8'd1;
      if (strobe) begin
        if (addr == ADDR_CTRL)
          ctrl <= data_wr[NUM_CH-1:0];
        if (addr == ADDR_PSC)
          prescale <= data_wr;
        for (int i = 0; i < NUM_CH; i++) begin
          if (sel_per[i])
            period_w[i] <= data_wr;
          if (sel_duty[i])
            duty_w[i] <= data_wr;
        end
      end
    end
  end

`ifdef PWM_SHADOW_EN
  // Active copy follows the shadow while idle, otherwise only at the wrap
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        period_a[i] <= 8'hFF;
        duty_a[i]   <= 8'h00;
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (!ctrl[i] || wrap[i]) begin
          period_a[i] <= period_w[i];
          duty_a[i]   <= duty_w[i];
        end
      end
    end
  end
`else
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      period_a[i] = period_w[i];
      duty_a[i]   = duty_w[i];
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_out <= '0;
      for (int i = 0; i < NUM_CH; i++)
        cnt[i] <= 8'h00;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        pwm_out[i] <= ctrl[i] & (cnt[i] < duty_a[i]);
        if (!ctrl[i] || wrap[i])
          cnt[i] <= 8'h00;
        else if (tick)
          cnt[i] <= cnt[i] + 8'd1;
      end
    end
  end

endmodule
